ex_mem_reg: RTL and testbench
=============================

EX_MEM_REG -- requirements
Module: ex_mem_reg

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock; rst  in  1  synchronous active-high reset.
REQ-002 SHALL have ports: stall  in  1  hold contents; flush  in  1  insert bubble.
REQ-003 SHALL have ports: ex_inst  in  32  instruction word; ex_C  in  32  ALU result/address; ex_busB  in  32  rt operand; ex_rw  in  5  destination register.
REQ-004 SHALL have ports: ex_RegWrite, ex_MemWrite, ex_MemtoReg, ex_sb, ex_lb, ex_lbu, ex_jal, ex_jalr  in  1 each  EX control.
REQ-005 SHALL have ports: C4  in  32  WB write-back data.
REQ-006 SHALL have ports: mem_inst  out  32; mem_C  out  32; dm_addr  out  12  (=mem_C[11:0]); busB  out  32; mem_rw  out  5.
REQ-007 SHALL have ports: mem_valid, mem_RegWrite, MemWrite, mem_MemtoReg, sb, lb, lbu, jal, jalr, ForwardD  out  1 each.

Function
REQ-008 SHALL register every output on rising clk; no combinational path from ex_* to outputs except dm_addr from mem_C.
REQ-009 Normal cycle (no rst/flush/stall): all mem_* fields SHALL load from ex_*, mem_valid=1, latency exactly 1 cycle.
REQ-010 flush=1 SHALL load a bubble: mem_valid=0, mem_inst=0, all control outputs and ForwardD=0; data fields don't-care but SHALL be 0.
REQ-011 stall=1, flush=0 SHALL hold all fields, except the ForwardD capture of REQ-014.
REQ-012 flush SHALL take priority over stall; rst over both.
REQ-013 ForwardD SHALL be set on load iff: ex_MemWrite=1, mem_RegWrite=1, mem_valid=1, mem_rw!=0, mem_rw==ex_inst[20:16]; else 0.
REQ-014 Stalled with ForwardD=1: busB SHALL capture C4 and ForwardD SHALL clear in that cycle, so the operand survives WB advancing.
REQ-015 Write to $0 (ex_rw=0) SHALL propagate unchanged; only forwarding ignores rw=0.
REQ-016 Consecutive forward-eligible stores SHALL each evaluate REQ-013 against the instruction then in MEM.
REQ-017 ex_sb/ex_lb/ex_lbu SHALL pass through unmodified; at most one is asserted by the decoder, not checked.

Reset
REQ-018 rst=1 at a clock edge SHALL clear all outputs to 0 (mem_valid=0, dm_addr=0), regardless of stall/flush.
REQ-019 rst asserted mid-stall SHALL discard held contents; first post-reset load follows REQ-009.

Structure
REQ-020 Shared package SHALL hold opcode/field constants (RT_MSB=20, RT_LSB=16, DM_AW=12) and the bubble value.
REQ-021 One sub-module natural: fwd_store_det (combinational REQ-013 compare); all state in ex_mem_reg.
REQ-022 Target 120-250 lines RTL; single always block per register group.

Verification
REQ-023 Pass-through: ex_C=0x0000_0A14, ex_RegWrite=1, ex_rw=8 -> next cycle mem_C=0x0A14, dm_addr=0xA14, mem_RegWrite=1, mem_rw=8, mem_valid=1.
REQ-024 Load-store forward: lw $9 in MEM (RegWrite=1, rw=9), then sw with rt=9 in EX -> next cycle ForwardD=1; with rt=10 -> ForwardD=0; rw=0 and rt=0 -> ForwardD=0.
REQ-025 Stall capture: ForwardD=1, stall=1, C4=0xDEAD_BEEF -> next cycle busB=0xDEADBEEF, ForwardD=0, other fields unchanged for 3 stall cycles.
REQ-026 Flush vs stall: stall=1, flush=1 with valid sw in EX -> next cycle mem_valid=0, MemWrite=0, ForwardD=0.
REQ-027 Reset: rst=1 during stall with populated register -> next cycle all outputs 0; release rst with ex_inst=0x2008_0005 -> mem_inst=0x20080005 one cycle later.

Source files
------------

// File: rtl/ex_mem_reg_pkg.sv
// Shared constants and types for the EX/MEM pipeline register.
// The MEM-stage state is one packed struct so that bubble/reset loads stay in a single assignment.
package ex_mem_reg_pkg;

    localparam int RT_MSB = 20;
    localparam int RT_LSB = 16;
    localparam int DM_AW  = 12;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] c;
        logic [31:0] busB;
        logic [4:0]  rw;
        logic        valid;
        logic        regWrite;
        logic        memWrite;
        logic        memtoReg;
        logic        sb;
        logic        lb;
        logic        lbu;
        logic        jal;
        logic        jalr;
        logic        forwardD;
    } mem_stage_t;

    localparam mem_stage_t MEM_BUBBLE = '0;

    function automatic logic [4:0] rt_field(input logic [31:0] inst);
        return inst[RT_MSB:RT_LSB];
    endfunction

endpackage

// File: rtl/ex_mem_reg_fwd_store_det.sv
// Flags a store in EX whose rt register is about to be written by the instruction now in MEM.
module ex_mem_reg_fwd_store_det (
    input  logic       ex_MemWrite_i,
    input  logic [4:0] ex_rt_i,
    input  logic       mem_valid_i,
    input  logic       mem_RegWrite_i,
    input  logic [4:0] mem_rw_i,
    output logic       fwd_o
);

    // $0 never carries a real value, so it is never a forwarding source.
    assign fwd_o = ex_MemWrite_i && mem_RegWrite_i && mem_valid_i
                   && (mem_rw_i != 5'd0) && (mem_rw_i == ex_rt_i);

endmodule

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register with stall, flush and store-data forwarding capture.
// All outputs come straight from the stage register; dm_addr is a slice of it.
module ex_mem_reg
    import ex_mem_reg_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] ex_inst,
    input  logic [31:0] ex_C,
    input  logic [31:0] ex_busB,
    input  logic [4:0]  ex_rw,
    input  logic        ex_RegWrite,
    input  logic        ex_MemWrite,
    input  logic        ex_MemtoReg,
    input  logic        ex_sb,
    input  logic        ex_lb,
    input  logic        ex_lbu,
    input  logic        ex_jal,
    input  logic        ex_jalr,
    input  logic [31:0] C4,
    output logic [31:0] mem_inst,
    output logic [31:0] mem_C,
    output logic [11:0] dm_addr,
    output logic [31:0] busB,
    output logic [4:0]  mem_rw,
    output logic        mem_valid,
    output logic        mem_RegWrite,
    output logic        MemWrite,
    output logic        mem_MemtoReg,
    output logic        sb,
    output logic        lb,
    output logic        lbu,
    output logic        jal,
    output logic        jalr,
    output logic        ForwardD
);

    mem_stage_t stage_q;
    mem_stage_t stage_d;
    logic       fwdHit;

    ex_mem_reg_fwd_store_det fwd_store_det (
        .ex_MemWrite_i  (ex_MemWrite),
        .ex_rt_i        (rt_field(ex_inst)),
        .mem_valid_i    (stage_q.valid),
        .mem_RegWrite_i (stage_q.regWrite),
        .mem_rw_i       (stage_q.rw),
        .fwd_o          (fwdHit)
    );

    // Flush beats stall. While stalled, a pending forward grabs the WB value
    // now, because the producer leaves WB before the store can use it.
    always_comb begin
        stage_d = stage_q;
        if (flush) begin
            stage_d = MEM_BUBBLE;
        end else if (stall) begin
            if (stage_q.forwardD) begin
                stage_d.busB     = C4;
                stage_d.forwardD = 1'b0;
            end
        end else begin
            stage_d.inst     = ex_inst;
            stage_d.c        = ex_C;
            stage_d.busB     = ex_busB;
            stage_d.rw       = ex_rw;
            stage_d.valid    = 1'b1;
            stage_d.regWrite = ex_RegWrite;
            stage_d.memWrite = ex_MemWrite;
            stage_d.memtoReg = ex_MemtoReg;
            stage_d.sb       = ex_sb;
            stage_d.lb       = ex_lb;
            stage_d.lbu      = ex_lbu;
            stage_d.jal      = ex_jal;
            stage_d.jalr     = ex_jalr;
            stage_d.forwardD = fwdHit;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stage_q <= MEM_BUBBLE;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign mem_inst     = stage_q.inst;
    assign mem_C        = stage_q.c;
    assign dm_addr      = stage_q.c[DM_AW-1:0];
    assign busB         = stage_q.busB;
    assign mem_rw       = stage_q.rw;
    assign mem_valid    = stage_q.valid;
    assign mem_RegWrite = stage_q.regWrite;
    assign MemWrite     = stage_q.memWrite;
    assign mem_MemtoReg = stage_q.memtoReg;
    assign sb           = stage_q.sb;
    assign lb           = stage_q.lb;
    assign lbu          = stage_q.lbu;
    assign jal          = stage_q.jal;
    assign jalr         = stage_q.jalr;
    assign ForwardD     = stage_q.forwardD;

endmodule

// File: tb/tb_ex_mem_reg.sv
// Directed bench for ex_mem_reg: pass-through, forwarding detect, stall capture, flush and reset.
module tb_ex_mem_reg;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        flush;
    logic [31:0] ex_inst;
    logic [31:0] ex_C;
    logic [31:0] ex_busB;
    logic [4:0]  ex_rw;
    logic        ex_RegWrite;
    logic        ex_MemWrite;
    logic        ex_MemtoReg;
    logic        ex_sb;
    logic        ex_lb;
    logic        ex_lbu;
    logic        ex_jal;
    logic        ex_jalr;
    logic [31:0] C4;
    logic [31:0] mem_inst;
    logic [31:0] mem_C;
    logic [11:0] dm_addr;
    logic [31:0] busB;
    logic [4:0]  mem_rw;
    logic        mem_valid;
    logic        mem_RegWrite;
    logic        MemWrite;
    logic        mem_MemtoReg;
    logic        sb;
    logic        lb;
    logic        lbu;
    logic        jal;
    logic        jalr;
    logic        ForwardD;

    int checks;
    int failures;

    // {valid, RegWrite, MemWrite, MemtoReg, sb, lb, lbu, jal, jalr, ForwardD}
    logic [9:0] ctrlObs;
    assign ctrlObs = {mem_valid, mem_RegWrite, MemWrite, mem_MemtoReg, sb, lb, lbu, jal, jalr, ForwardD};

    localparam logic [31:0] LW9   = 32'h8C09_0000;
    localparam logic [31:0] LW0   = 32'h8C00_0000;
    localparam logic [31:0] SW9   = 32'hAC09_0004;
    localparam logic [31:0] SW10  = 32'hAC0A_0004;
    localparam logic [31:0] SW0   = 32'hAC00_0004;
    localparam logic [31:0] ADDI8 = 32'h2008_0005;

    ex_mem_reg dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .ex_inst(ex_inst), .ex_C(ex_C), .ex_busB(ex_busB), .ex_rw(ex_rw),
        .ex_RegWrite(ex_RegWrite), .ex_MemWrite(ex_MemWrite), .ex_MemtoReg(ex_MemtoReg),
        .ex_sb(ex_sb), .ex_lb(ex_lb), .ex_lbu(ex_lbu), .ex_jal(ex_jal), .ex_jalr(ex_jalr),
        .C4(C4),
        .mem_inst(mem_inst), .mem_C(mem_C), .dm_addr(dm_addr), .busB(busB), .mem_rw(mem_rw),
        .mem_valid(mem_valid), .mem_RegWrite(mem_RegWrite), .MemWrite(MemWrite),
        .mem_MemtoReg(mem_MemtoReg), .sb(sb), .lb(lb), .lbu(lbu), .jal(jal), .jalr(jalr),
        .ForwardD(ForwardD)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ctrl = {RegWrite, MemWrite, MemtoReg, sb, lb, lbu, jal, jalr}
    task automatic setEx(input logic [31:0] inst, input logic [31:0] c, input logic [31:0] bb,
                         input logic [4:0] rw, input logic [7:0] ctrl);
        ex_inst = inst;
        ex_C    = c;
        ex_busB = bb;
        ex_rw   = rw;
        {ex_RegWrite, ex_MemWrite, ex_MemtoReg, ex_sb, ex_lb, ex_lbu, ex_jal, ex_jalr} = ctrl;
    endtask

    task automatic test_reset();
        rst = 1'b1; stall = 1'b1; flush = 1'b0;
        setEx(32'hFFFF_FFFF, 32'h1234_5678, 32'h9ABC_DEF0, 5'd31, 8'hFF);
        tick();
        tick();
        checks++;
        if (ctrlObs !== 10'b0) begin
            failures++; $display("[TB] FAIL reset_ctrl: got %b expected %b", ctrlObs, 10'b0);
        end
        checks++;
        if ({mem_inst, mem_C, busB, mem_rw, dm_addr} !== '0) begin
            failures++; $display("[TB] FAIL reset_data: inst=%h C=%h busB=%h rw=%0d addr=%h expected all 0",
                                 mem_inst, mem_C, busB, mem_rw, dm_addr);
        end
        rst = 1'b0; stall = 1'b0;
    endtask

    task automatic test_pass_through();
        setEx(32'h0109_5020, 32'h0000_0A14, 32'h0000_0077, 5'd8, 8'b1000_0000);
        tick();
        checks++;
        if (mem_C !== 32'h0000_0A14) begin
            failures++; $display("[TB] FAIL pass_memC: got %h expected %h", mem_C, 32'h0000_0A14);
        end
        checks++;
        if (dm_addr !== 12'hA14) begin
            failures++; $display("[TB] FAIL pass_dm_addr: got %h expected %h", dm_addr, 12'hA14);
        end
        checks++;
        if (mem_rw !== 5'd8 || mem_inst !== 32'h0109_5020 || busB !== 32'h0000_0077) begin
            failures++; $display("[TB] FAIL pass_fields: rw=%0d inst=%h busB=%h expected 8 01095020 00000077",
                                 mem_rw, mem_inst, busB);
        end
        checks++;
        if (ctrlObs !== 10'b1100000000) begin
            failures++; $display("[TB] FAIL pass_ctrl: got %b expected %b", ctrlObs, 10'b1100000000);
        end
        // rt of inst 0 is $0, so no forwarding even though MEM writes $8
        setEx(32'h0, 32'h0000_1FFF, 32'h0, 5'd0, 8'b0101_0010);
        tick();
        checks++;
        if (ctrlObs !== 10'b1010100100) begin
            failures++; $display("[TB] FAIL pass_ctrl_sb_jal: got %b expected %b", ctrlObs, 10'b1010100100);
        end
        checks++;
        if (dm_addr !== 12'hFFF) begin
            failures++; $display("[TB] FAIL pass_dm_addr_trunc: got %h expected %h", dm_addr, 12'hFFF);
        end
        setEx(32'h0, 32'h0, 32'h0, 5'd0, 8'b1010_0101);
        tick();
        checks++;
        if (ctrlObs !== 10'b1101001010 || mem_rw !== 5'd0) begin
            failures++; $display("[TB] FAIL pass_write_r0: ctrl=%b rw=%0d expected %b 0", ctrlObs, mem_rw, 10'b1101001010);
        end
    endtask

    task automatic test_forward();
        setEx(LW9, 32'h0, 32'h0, 5'd9, 8'b1010_0000);
        tick();
        setEx(SW9, 32'h4, 32'h0, 5'd0, 8'b0100_0000);
        tick();
        checks++;
        if (ctrlObs !== 10'b1010000001) begin
            failures++; $display("[TB] FAIL fwd_rt_match: got %b expected %b", ctrlObs, 10'b1010000001);
        end
        // MEM now holds a store, which does not write a register
        tick();
        checks++;
        if (ForwardD !== 1'b0) begin
            failures++; $display("[TB] FAIL fwd_back_to_back: got %b expected %b", ForwardD, 1'b0);
        end
        setEx(LW9, 32'h0, 32'h0, 5'd9, 8'b1010_0000);
        tick();
        setEx(SW10, 32'h4, 32'h0, 5'd0, 8'b0100_0000);
        tick();
        checks++;
        if (ForwardD !== 1'b0) begin
            failures++; $display("[TB] FAIL fwd_rt_differs: got %b expected %b", ForwardD, 1'b0);
        end
        setEx(LW0, 32'h0, 32'h0, 5'd0, 8'b1010_0000);
        tick();
        setEx(SW0, 32'h4, 32'h0, 5'd0, 8'b0100_0000);
        tick();
        checks++;
        if (ForwardD !== 1'b0) begin
            failures++; $display("[TB] FAIL fwd_reg_zero: got %b expected %b", ForwardD, 1'b0);
        end
    endtask

    task automatic test_stall_capture();
        setEx(LW9, 32'h0, 32'h0, 5'd9, 8'b1010_0000);
        tick();
        setEx(SW9, 32'h40, 32'h0000_1111, 5'd0, 8'b0100_0000);
        tick();
        checks++;
        if (ForwardD !== 1'b1 || busB !== 32'h0000_1111) begin
            failures++; $display("[TB] FAIL stall_setup: FD=%b busB=%h expected 1 00001111", ForwardD, busB);
        end
        stall = 1'b1;
        C4 = 32'hDEAD_BEEF;
        setEx(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd31, 8'hFF);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (busB !== 32'hDEAD_BEEF || ctrlObs !== 10'b1010000000) begin
                failures++; $display("[TB] FAIL stall_capture_%0d: busB=%h ctrl=%b expected deadbeef %b",
                                     i, busB, ctrlObs, 10'b1010000000);
            end
            checks++;
            if (mem_inst !== SW9 || mem_C !== 32'h40 || mem_rw !== 5'd0) begin
                failures++; $display("[TB] FAIL stall_hold_%0d: inst=%h C=%h rw=%0d expected %h 00000040 0",
                                     i, mem_inst, mem_C, mem_rw, SW9);
            end
            C4 = 32'h1234_5678;
        end
        stall = 1'b0;
    endtask

    task automatic test_flush_vs_stall();
        setEx(LW9, 32'h8, 32'h0, 5'd9, 8'b1010_0000);
        tick();
        stall = 1'b1; flush = 1'b1;
        setEx(SW9, 32'h44, 32'h55, 5'd0, 8'b0100_0000);
        tick();
        checks++;
        if (ctrlObs !== 10'b0) begin
            failures++; $display("[TB] FAIL flush_ctrl: got %b expected %b", ctrlObs, 10'b0);
        end
        checks++;
        if ({mem_inst, mem_C, busB, mem_rw} !== '0) begin
            failures++; $display("[TB] FAIL flush_data: inst=%h C=%h busB=%h rw=%0d expected all 0",
                                 mem_inst, mem_C, busB, mem_rw);
        end
        stall = 1'b0; flush = 1'b0;
    endtask

    task automatic test_reset_mid_stall();
        setEx(LW9, 32'h0000_0ABC, 32'h77, 5'd9, 8'b1010_0000);
        tick();
        stall = 1'b1;
        setEx(ADDI8, 32'h0, 32'h0, 5'd8, 8'b1000_0000);
        tick();
        checks++;
        if (mem_inst !== LW9 || dm_addr !== 12'hABC) begin
            failures++; $display("[TB] FAIL rst_pre_hold: inst=%h addr=%h expected %h abc", mem_inst, dm_addr, LW9);
        end
        rst = 1'b1;
        tick();
        checks++;
        if (ctrlObs !== 10'b0 || {mem_inst, mem_C, busB, mem_rw, dm_addr} !== '0) begin
            failures++; $display("[TB] FAIL rst_mid_stall: ctrl=%b inst=%h C=%h busB=%h expected all 0",
                                 ctrlObs, mem_inst, mem_C, busB);
        end
        rst = 1'b0; stall = 1'b0;
        tick();
        checks++;
        if (mem_inst !== ADDI8 || ctrlObs !== 10'b1100000000 || mem_rw !== 5'd8) begin
            failures++; $display("[TB] FAIL rst_first_load: inst=%h ctrl=%b rw=%0d expected %h %b 8",
                                 mem_inst, ctrlObs, mem_rw, ADDI8, 10'b1100000000);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1; stall = 1'b0; flush = 1'b0; C4 = 32'h0;
        setEx(32'h0, 32'h0, 32'h0, 5'd0, 8'h00);
        test_reset();
        test_pass_through();
        test_forward();
        test_stall_capture();
        test_flush_vs_stall();
        test_reset_mid_stall();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
